// File: rtl/fsm_host_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin host scheduler.
package fsm_host_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned ENABLE_CYCLES_DEF  = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    // Width of a down/up counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_host_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        idx        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = i + 32'(ptr);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && req[IDX_W'(idx)]) begin
                gnt_any                    = 1'b1;
                gnt_idx                    = IDX_W'(idx);
                gnt_onehot[IDX_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_host_rr_scheduler.sv
// Shares one trojan1_fsm_host pipeline among NUM_REQ requesters, round-robin.
// Define ARB_TIMEOUT_EN to build the WAIT-state watchdog (resp_err path).
module fsm_host_rr_scheduler
    import fsm_host_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ENABLE_CYCLES  = ENABLE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic                          busy,
    output logic                          host_enable,
    output logic [DATA_WIDTH-1:0]         host_data_in,
    input  logic                          host_valid,
    input  logic [DATA_WIDTH-1:0]         host_data_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned ENA_W = cnt_width(ENABLE_CYCLES);

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ENA_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  host_valid_q;
    logic                  host_valid_rise;

    logic [NUM_REQ-1:0]    arb_onehot;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
    logic [TO_W-1:0] wd_q, wd_d;
    logic            resp_err_q, resp_err_d;
`endif

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    assign host_valid_rise = host_valid & ~host_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            host_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_q         <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            host_valid_q <= host_valid;
`ifdef ARB_TIMEOUT_EN
            wd_q         <= wd_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
`ifdef ARB_TIMEOUT_EN
        wd_d        = wd_q;
        resp_err_d  = resp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d   = ST_DRIVE;
                    ptr_d     = arb_idx;
                    gnt_d     = arb_onehot;
                    data_d    = req_data[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
                    cnt_d     = ENA_W'(ENABLE_CYCLES - 1);
                    resp_id_d = arb_idx;
`ifdef ARB_TIMEOUT_EN
                    resp_err_d = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (host_valid_rise) begin
                    resp_data_d = host_data_out;
                    state_d     = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Host-facing strobes are pure functions of state, so enable can never leak outside DRIVE.
    always_comb begin
        host_enable  = (state_q == ST_DRIVE);
        host_data_in = (state_q == ST_DRIVE) ? data_q : '0;
        resp_valid   = (state_q == ST_RESP);
        busy         = (state_q != ST_IDLE);
    end

    assign gnt       = gnt_q;
    assign resp_id   = resp_id_q;
    assign resp_data = resp_data_q;
`ifdef ARB_TIMEOUT_EN
    assign resp_err  = resp_err_q;
`else
    assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_host_rr_scheduler.sv
// Directed self-checking bench for fsm_host_rr_scheduler with a behavioural host model.
// The host returns data_in ^ 8'hCC one cycle after its enable window closes.
module tb_fsm_host_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic        busy;
    logic        host_enable;
    logic [7:0]  host_data_in;
    logic        host_valid;
    logic [7:0]  host_data_out;

    int cmp_count = 0;
    int err_count = 0;

    logic       host_kill;
    logic [7:0] h_acc;
    logic       h_load;
    logic       h_valid_r;
    logic [7:0] h_out;

    fsm_host_rr_scheduler #(
        .NUM_REQ        (4),
        .DATA_WIDTH     (8),
        .ENABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .busy          (busy),
        .host_enable   (host_enable),
        .host_data_in  (host_data_in),
        .host_valid    (host_valid),
        .host_data_out (host_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host: loads while enabled, outputs one cycle after enable drops, valid pulse next cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h_acc     <= 8'h00;
            h_load    <= 1'b0;
            h_valid_r <= 1'b0;
            h_out     <= 8'h00;
        end else begin
            h_valid_r <= 1'b0;
            if (host_enable) begin
                h_acc  <= host_data_in;
                h_load <= 1'b1;
            end else if (h_load) begin
                h_load    <= 1'b0;
                h_valid_r <= 1'b1;
                h_out     <= h_acc ^ 8'hCC;
            end
        end
    end
    assign host_valid    = h_valid_r & ~host_kill;
    assign host_data_out = h_out;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    // Counts negedges until resp_valid is seen; n = -1 if limit expires.
    task automatic wait_resp(input int limit, output int n);
        n = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_count++;
        if ({gnt, resp_valid, resp_id, resp_data, resp_err, busy, host_enable, host_data_in} !== '0) begin
            err_count++;
            $display("FAIL reset_outputs got gnt=%b rv=%b id=%0d data=%h err=%b busy=%b en=%b din=%h exp all 0",
                     gnt, resp_valid, resp_id, resp_data, resp_err, busy, host_enable, host_data_in);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] exp_gnt;
        logic       exp_en;
        logic       exp_rv;
        start_cycle();
        req        = 4'b0001;
        req_data   = 32'h0000_0010;
        resp_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            exp_gnt = (c >= 1) ? 4'b0001 : 4'b0000;
            exp_en  = (c >= 1 && c <= 4);
            exp_rv  = (c == 7);
            cmp_count++;
            if (gnt !== exp_gnt || host_enable !== exp_en || resp_valid !== exp_rv ||
                busy !== (c >= 1)) begin
                err_count++;
                $display("FAIL single_timing cyc=%0d got gnt=%b en=%b rv=%b busy=%b exp gnt=%b en=%b rv=%b busy=%b",
                         c, gnt, host_enable, resp_valid, busy, exp_gnt, exp_en, exp_rv, (c >= 1));
            end
            if (exp_en) begin
                cmp_count++;
                if (host_data_in !== 8'h10) begin
                    err_count++;
                    $display("FAIL single_data_in cyc=%0d got=%h exp=10", c, host_data_in);
                end
            end
        end
        cmp_count++;
        if (resp_id !== 2'd0 || resp_data !== 8'hDC || resp_err !== 1'b0) begin
            err_count++;
            $display("FAIL single_resp got id=%0d data=%h err=%b exp id=0 data=dc err=0",
                     resp_id, resp_data, resp_err);
        end
        req = 4'b0000;
        @(negedge clk);
        cmp_count++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || resp_valid !== 1'b0) begin
            err_count++;
            $display("FAIL single_after_accept got busy=%b gnt=%b rv=%b exp 0 0000 0", busy, gnt, resp_valid);
        end
    endtask

    task automatic test_rotate();
        int n;
        logic [1:0] exp_id[5];
        logic [7:0] exp_dat[5];
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{8'hCD, 8'hCE, 8'hCF, 8'hC8, 8'hCD};
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_cycle();
        req        = 4'b1111;
        req_data   = 32'h0403_0201;
        resp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_resp(20, n);
            cmp_count++;
            if (n !== 7 || resp_id !== exp_id[j] || resp_data !== exp_dat[j]) begin
                err_count++;
                $display("FAIL rotate_job%0d got wait=%0d id=%0d data=%h exp wait=7 id=%0d data=%h",
                         j, n, resp_id, resp_data, exp_id[j], exp_dat[j]);
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        start_cycle();
        req        = 4'b0010;
        req_data   = 32'hA500_5A00;
        resp_ready = 1'b0;
        wait_resp(20, n);
        cmp_count++;
        if (n !== 7 || resp_id !== 2'd1 || resp_data !== 8'h96) begin
            err_count++;
            $display("FAIL bp_first got wait=%0d id=%0d data=%h exp wait=7 id=1 data=96", n, resp_id, resp_data);
        end
        req = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp_count++;
            if (resp_valid !== 1'b1 || resp_data !== 8'h96 || resp_id !== 2'd1 ||
                host_enable !== 1'b0 || gnt !== 4'b0010) begin
                err_count++;
                $display("FAIL bp_hold c=%0d got rv=%b data=%h id=%0d en=%b gnt=%b exp 1 96 1 0 0010",
                         c, resp_valid, resp_data, resp_id, host_enable, gnt);
            end
        end
        resp_ready = 1'b1;
        req        = 4'b1000;
        @(negedge clk);
        cmp_count++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || resp_valid !== 1'b0) begin
            err_count++;
            $display("FAIL bp_idle got busy=%b gnt=%b rv=%b exp 0 0000 0", busy, gnt, resp_valid);
        end
        @(negedge clk);
        cmp_count++;
        if (gnt !== 4'b1000 || host_enable !== 1'b1 || host_data_in !== 8'hA5) begin
            err_count++;
            $display("FAIL bp_next_grant got gnt=%b en=%b din=%h exp 1000 1 a5", gnt, host_enable, host_data_in);
        end
        wait_resp(20, n);
        cmp_count++;
        if (n !== 5 || resp_id !== 2'd3 || resp_data !== 8'h69) begin
            err_count++;
            $display("FAIL bp_second got wait=%0d id=%0d data=%h exp wait=5 id=3 data=69", n, resp_id, resp_data);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_drop();
        int n;
        start_cycle();
        req        = 4'b0100;
        req_data   = 32'h0033_0000;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmp_count++;
        if (gnt !== 4'b0100 || host_enable !== 1'b1) begin
            err_count++;
            $display("FAIL drop_grant got gnt=%b en=%b exp 0100 1", gnt, host_enable);
        end
        req = 4'b0000;
        wait_resp(20, n);
        cmp_count++;
        if (n !== 4 || resp_id !== 2'd2 || resp_data !== 8'hFF) begin
            err_count++;
            $display("FAIL drop_resp got wait=%0d id=%0d data=%h exp wait=4 id=2 data=ff", n, resp_id, resp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int n;
        start_cycle();
        req        = 4'b0001;
        req_data   = 32'h0000_0077;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        cmp_count++;
        if ({gnt, resp_valid, busy, host_enable, host_data_in, resp_err} !== '0) begin
            err_count++;
            $display("FAIL rst_mid_outputs got gnt=%b rv=%b busy=%b en=%b din=%h err=%b exp all 0",
                     gnt, resp_valid, busy, host_enable, host_data_in, resp_err);
        end
        req = 4'b0000;
        @(negedge clk);
        cmp_count++;
        if (busy !== 1'b0 || host_enable !== 1'b0 || gnt !== 4'b0000) begin
            err_count++;
            $display("FAIL rst_mid_held got busy=%b en=%b gnt=%b exp 0 0 0000", busy, host_enable, gnt);
        end
        rst = 1'b0;
        start_cycle();
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        cmp_count++;
        if (gnt !== 4'b0001 || host_enable !== 1'b1 || host_data_in !== 8'h77) begin
            err_count++;
            $display("FAIL rst_mid_regrant got gnt=%b en=%b din=%h exp 0001 1 77", gnt, host_enable, host_data_in);
        end
        req = 4'b0000;
        wait_resp(20, n);
        cmp_count++;
        if (n !== 5 || resp_id !== 2'd0 || resp_data !== 8'hBB) begin
            err_count++;
            $display("FAIL rst_mid_resp got wait=%0d id=%0d data=%h exp wait=5 id=0 data=bb", n, resp_id, resp_data);
        end
        @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        host_kill = 1'b1;
        start_cycle();
        req        = 4'b0001;
        req_data   = 32'h0000_0042;
        resp_ready = 1'b1;
        wait_resp(40, n);
        cmp_count++;
        if (n !== 21 || resp_err !== 1'b1 || resp_data !== 8'h00 || resp_id !== 2'd0) begin
            err_count++;
            $display("FAIL timeout_resp got wait=%0d err=%b data=%h id=%0d exp wait=21 err=1 data=00 id=0",
                     n, resp_err, resp_data, resp_id);
        end
        req       = 4'b0000;
        host_kill = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        req_data   = 32'h0;
        resp_ready = 1'b0;
        host_kill  = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_backpressure();
        test_drop();
        test_rst_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
